pc_next_unit: RTL

Program-counter stage for the 16-bit datapath. Holds the current PC, produces the sequential successor, and accepts the branch-resolved redirect that the 2:1 next-PC mux stage consumes. Adds a boot state, a stall freeze with a one-entry pending-redirect buffer so no branch is lost during a stall, and a halt/resume state machine.

---
 rtl/pc_next_unit_if.sv | 34 +++
 rtl/pc_next_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pc_next_unit_if.sv
// rtl/pc_next_unit_if.sv - control inputs and PC outputs of pc_next_unit (branch_count under PC_BRANCH_COUNT_EN)
interface pc_next_unit_if #(
  parameter int WIDTH = 16
);
  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             halt;
  logic             resume;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic             pc_valid;
  logic             halted;
  logic             redirect_pending;
`ifdef PC_BRANCH_COUNT_EN
  logic [7:0]       branch_count;
`endif

  modport master (
    output stall, branch_taken, branch_target, halt, resume,
    input  pc, pc_plus, pc_valid, halted, redirect_pending
`ifdef PC_BRANCH_COUNT_EN
    , input branch_count
`endif
  );

  modport slave (
    input  stall, branch_taken, branch_target, halt, resume,
    output pc, pc_plus, pc_valid, halted, redirect_pending
`ifdef PC_BRANCH_COUNT_EN
    , output branch_count
`endif
  );
endinterface

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - PC stage with boot, stall-safe redirect buffer and halt/resume; PC_BRANCH_COUNT_EN adds branch_count
module pc_next_unit #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INCR         = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_next_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] INCR_W = WIDTH'(INCR);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             halted_q, halted_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] target_even;

  assign pc_plus     = pc_q + INCR_W;
  assign target_even = {bus.branch_target[WIDTH-1:1], 1'b0};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    halted_d   = halted_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    unique case (state_q)
      ST_BOOT: begin
        // First fetch is the reset vector itself, so pc is not advanced here.
        state_d    = ST_RUN;
        pc_valid_d = 1'b1;
      end
      ST_RUN: begin
        if (bus.halt) begin
          state_d    = ST_HALTED;
          pc_valid_d = 1'b0;
          halted_d   = 1'b1;
          pend_d     = 1'b0;
          pend_tgt_d = '0;
        end else if (bus.stall && bus.branch_taken) begin
          pend_d     = 1'b1;
          pend_tgt_d = target_even;
        end else if (bus.stall) begin
          pend_d = pend_q;
        end else if (bus.branch_taken) begin
          // A live branch is younger than any buffered one and supersedes it.
          pc_d   = target_even;
          pend_d = 1'b0;
        end else if (pend_q) begin
          pc_d   = pend_tgt_q;
          pend_d = 1'b0;
        end else begin
          pc_d = pc_plus;
        end
      end
      ST_HALTED: begin
        if (bus.resume && !bus.halt) begin
          state_d    = ST_RUN;
          pc_valid_d = 1'b1;
          halted_d   = 1'b0;
        end
      end
      default: begin
        state_d    = ST_BOOT;
        pc_valid_d = 1'b0;
        halted_d   = 1'b0;
        pend_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      halted_q   <= halted_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pc_plus          = pc_plus;
  assign bus.pc_valid         = pc_valid_q;
  assign bus.halted           = halted_q;
  assign bus.redirect_pending = pend_q;

`ifdef PC_BRANCH_COUNT_EN
  logic       redirect_load;
  logic [7:0] branch_count_q, branch_count_d;

  // Mirrors the two RUN cases above that load pc from a redirect.
  assign redirect_load = (state_q == ST_RUN) && !bus.halt && !bus.stall &&
                         (bus.branch_taken || pend_q);

  always_comb begin
    branch_count_d = branch_count_q;
    if (redirect_load && (branch_count_q != 8'hFF)) begin
      branch_count_d = branch_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_q <= 8'h00;
    end else begin
      branch_count_q <= branch_count_d;
    end
  end

  assign bus.branch_count = branch_count_q;
`endif

endmodule
